// File: rtl/bus_slave_ram_if.sv
// Crossbar slave-side request/response bundle for bus_slave_ram.
interface bus_slave_ram_if;
  logic        req;
  logic        cmd;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        ack;
  logic [31:0] rdata;

  modport master (output req, cmd, addr, wdata, input ack, rdata);
  modport slave  (input req, cmd, addr, wdata, output ack, rdata);
endinterface

// File: rtl/bus_slave_ram.sv
// Word-addressed RAM slave with programmable response latency and a completed-transaction counter.
// state  | meaning
// IDLE   | waiting for req; captures cmd/index/wdata when it arrives
// WAIT   | latency timer running on captured request
// ACK    | one-cycle ack pulse; memory access done on entry
module bus_slave_ram #(
  parameter int DEPTH       = 16,
  parameter int WAIT_CYCLES = 1,
  parameter int CNT_W       = 16
) (
  input  logic             clk,
  input  logic             arst,
  bus_slave_ram_if.slave   bus,
  output logic             busy,
  output logic [CNT_W-1:0] txn_count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [7:0] WAIT_LOAD = (WAIT_CYCLES > 0) ? 8'(WAIT_CYCLES - 1) : 8'd0;

  typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_ACK} state_t;

  state_t        state;
  logic [7:0]    wait_cnt;
  logic          wait_tc;
  logic          cap_cmd;
  logic [AW-1:0] cap_idx;
  logic [31:0]   cap_wdata;
  logic [31:0]   mem [DEPTH];

  logic unused_addr_bits;
  assign unused_addr_bits = ^{bus.addr[31:AW+2], bus.addr[1:0]};

  // wait_tc registers the terminal count so ACK follows one edge after the timer reads zero;
  // with WAIT_CYCLES=0 it is preset at capture, giving ACK on the very next edge.
  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      state     <= ST_IDLE;
      bus.ack   <= 1'b0;
      bus.rdata <= '0;
      busy      <= 1'b0;
      txn_count <= '0;
      wait_cnt  <= '0;
      wait_tc   <= 1'b0;
      cap_cmd   <= 1'b0;
      cap_idx   <= '0;
      cap_wdata <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (bus.req) begin
            cap_cmd   <= bus.cmd;
            cap_idx   <= bus.addr[AW+1:2];
            cap_wdata <= bus.wdata;
            wait_cnt  <= WAIT_LOAD;
            wait_tc   <= (WAIT_CYCLES == 0);
            busy      <= 1'b1;
            state     <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (wait_tc) begin
            state     <= ST_ACK;
            bus.ack   <= 1'b1;
            txn_count <= txn_count + CNT_W'(1);
            if (cap_cmd) mem[cap_idx] <= cap_wdata;
            else         bus.rdata    <= mem[cap_idx];
          end else if (wait_cnt == 8'd0) begin
            wait_tc <= 1'b1;
          end else begin
            wait_cnt <= wait_cnt - 8'd1;
          end
        end
        ST_ACK: begin
          bus.ack <= 1'b0;
          busy    <= 1'b0;
          state   <= ST_IDLE;
        end
        default: begin
          bus.ack <= 1'b0;
          busy    <= 1'b0;
          state   <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bus_slave_ram.sv
// Directed self-checking bench for bus_slave_ram: latency, capture, aliasing, abort, counter wrap.
module tb_bus_slave_ram;

  logic clk = 1'b0;
  logic arst = 1'b1;
  always #5 clk = ~clk;

  bus_slave_ram_if bm ();
  bus_slave_ram_if bz ();
  bus_slave_ram_if bw ();

  logic        busy_m, busy_z, busy_w;
  logic [15:0] txn_m, txn_z;
  logic [3:0]  txn_w;

  bus_slave_ram #(.DEPTH(16), .WAIT_CYCLES(1), .CNT_W(16)) dut_m (
    .clk(clk), .arst(arst), .bus(bm), .busy(busy_m), .txn_count(txn_m));
  bus_slave_ram #(.DEPTH(16), .WAIT_CYCLES(0), .CNT_W(16)) dut_z (
    .clk(clk), .arst(arst), .bus(bz), .busy(busy_z), .txn_count(txn_z));
  bus_slave_ram #(.DEPTH(16), .WAIT_CYCLES(1), .CNT_W(4)) dut_w (
    .clk(clk), .arst(arst), .bus(bw), .busy(busy_w), .txn_count(txn_w));

  int n_cmp = 0;
  int n_err = 0;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // lat counts edges from the capture edge through the edge that raises ack
  task automatic main_txn(input logic c, input logic [31:0] a, input logic [31:0] d,
                          output int lat, output logic [31:0] rd);
    bm.req = 1'b1; bm.cmd = c; bm.addr = a; bm.wdata = d;
    lat = 0;
    do begin
      tick();
      lat++;
    end while (!bm.ack && lat < 20);
    bm.req = 1'b0;
    rd = bm.rdata;
    tick();
  endtask

  task automatic test_reset();
    int lat;
    logic [31:0] rd;
    #12;
    n_cmp++; if (bm.ack !== 1'b0) begin n_err++; $display("FAIL rst_ack: got %b expected 0", bm.ack); end
    n_cmp++; if (bm.rdata !== 32'h0) begin n_err++; $display("FAIL rst_rdata: got %h expected 0", bm.rdata); end
    n_cmp++; if (txn_m !== 16'h0) begin n_err++; $display("FAIL rst_txn: got %h expected 0", txn_m); end
    n_cmp++; if (busy_m !== 1'b0) begin n_err++; $display("FAIL rst_busy: got %b expected 0", busy_m); end
    tick();
    arst = 1'b0;
    tick();
    bm.req = 1'b1; bm.cmd = 1'b1; bm.addr = 32'h8; bm.wdata = 32'hDEADBEEF;
    tick();
    tick();
    arst = 1'b1;
    #2;
    n_cmp++; if (bm.ack !== 1'b0) begin n_err++; $display("FAIL midrst_ack: got %b expected 0", bm.ack); end
    n_cmp++; if (bm.rdata !== 32'h0) begin n_err++; $display("FAIL midrst_rdata: got %h expected 0", bm.rdata); end
    n_cmp++; if (txn_m !== 16'h0) begin n_err++; $display("FAIL midrst_txn: got %h expected 0", txn_m); end
    n_cmp++; if (busy_m !== 1'b0) begin n_err++; $display("FAIL midrst_busy: got %b expected 0", busy_m); end
    bm.req = 1'b0;
    #1;
    arst = 1'b0;
    tick();
    main_txn(1'b0, 32'h8, 32'h0, lat, rd);
    n_cmp++; if (lat !== 3) begin n_err++; $display("FAIL rst_read_lat: got %0d expected 3", lat); end
    n_cmp++; if (rd !== 32'h0) begin n_err++; $display("FAIL rst_read_data: got %h expected 0", rd); end
  endtask

  task automatic test_latency();
    int lat;
    logic [31:0] rd;
    arst = 1'b1;
    #2;
    arst = 1'b0;
    tick();
    main_txn(1'b1, 32'h4, 32'h12345678, lat, rd);
    n_cmp++; if (lat !== 3) begin n_err++; $display("FAIL w1_write_lat: got %0d expected 3", lat); end
    n_cmp++; if (rd !== 32'h0) begin n_err++; $display("FAIL w1_write_rdata_held: got %h expected 0", rd); end
    n_cmp++; if (bm.ack !== 1'b0) begin n_err++; $display("FAIL w1_ack_width: got %b expected 0", bm.ack); end
    n_cmp++; if (busy_m !== 1'b0) begin n_err++; $display("FAIL w1_busy_idle: got %b expected 0", busy_m); end
    main_txn(1'b0, 32'h4, 32'h0, lat, rd);
    n_cmp++; if (lat !== 3) begin n_err++; $display("FAIL w1_read_lat: got %0d expected 3", lat); end
    n_cmp++; if (rd !== 32'h12345678) begin n_err++; $display("FAIL w1_read_data: got %h expected 12345678", rd); end
    n_cmp++; if (txn_m !== 16'd2) begin n_err++; $display("FAIL w1_txn: got %0d expected 2", txn_m); end
  endtask

  task automatic test_back_to_back();
    logic [5:0] acks;
    int lat;
    acks = '0;
    bz.req = 1'b1; bz.cmd = 1'b1; bz.addr = 32'h10; bz.wdata = 32'hAAAA0001;
    for (int i = 0; i < 6; i++) begin
      tick();
      acks[i] = bz.ack;
      if (i == 1) begin bz.addr = 32'h14; bz.wdata = 32'hAAAA0002; end
      if (i == 4) bz.req = 1'b0;
    end
    n_cmp++; if (acks !== 6'b010010) begin n_err++; $display("FAIL b2b_ack_pattern: got %b expected 010010", acks); end
    n_cmp++; if (txn_z !== 16'd2) begin n_err++; $display("FAIL b2b_txn: got %0d expected 2", txn_z); end
    tick();
    bz.req = 1'b1; bz.cmd = 1'b0; bz.addr = 32'h14;
    lat = 0;
    do begin
      tick();
      lat++;
    end while (!bz.ack && lat < 20);
    bz.req = 1'b0;
    n_cmp++; if (lat !== 2) begin n_err++; $display("FAIL w0_read_lat: got %0d expected 2", lat); end
    n_cmp++; if (bz.rdata !== 32'hAAAA0002) begin n_err++; $display("FAIL b2b_read_data: got %h expected aaaa0002", bz.rdata); end
    tick();
  endtask

  task automatic test_capture();
    int lat;
    logic [31:0] rd;
    bm.req = 1'b1; bm.cmd = 1'b1; bm.addr = 32'h0; bm.wdata = 32'hA5A5A5A5;
    tick();
    lat = 1;
    bm.addr = 32'hC; bm.wdata = 32'hFFFFFFFF; bm.cmd = 1'b0;
    while (!bm.ack && lat < 20) begin
      tick();
      lat++;
    end
    bm.req = 1'b0;
    n_cmp++; if (lat !== 3) begin n_err++; $display("FAIL cap_lat: got %0d expected 3", lat); end
    tick();
    main_txn(1'b0, 32'h0, 32'h0, lat, rd);
    n_cmp++; if (rd !== 32'hA5A5A5A5) begin n_err++; $display("FAIL cap_word0: got %h expected a5a5a5a5", rd); end
    main_txn(1'b0, 32'hC, 32'h0, lat, rd);
    n_cmp++; if (rd !== 32'h0) begin n_err++; $display("FAIL cap_word3: got %h expected 0", rd); end
  endtask

  task automatic test_alias();
    int lat;
    logic [31:0] rd;
    main_txn(1'b1, 32'h40, 32'h11111111, lat, rd);
    main_txn(1'b0, 32'h0, 32'h0, lat, rd);
    n_cmp++; if (rd !== 32'h11111111) begin n_err++; $display("FAIL alias_0x40: got %h expected 11111111", rd); end
    main_txn(1'b1, 32'h80000003, 32'h22222222, lat, rd);
    main_txn(1'b0, 32'h0, 32'h0, lat, rd);
    n_cmp++; if (rd !== 32'h22222222) begin n_err++; $display("FAIL alias_hi_lo: got %h expected 22222222", rd); end
  endtask

  task automatic test_abort_wrap();
    int lat;
    bw.req = 1'b1; bw.cmd = 1'b1; bw.addr = 32'h4; bw.wdata = 32'h5;
    tick();
    bw.req = 1'b0;
    lat = 1;
    while (!bw.ack && lat < 20) begin
      tick();
      lat++;
    end
    n_cmp++; if (lat !== 3) begin n_err++; $display("FAIL abort_ack_lat: got %0d expected 3", lat); end
    tick();
    n_cmp++; if (txn_w !== 4'd1) begin n_err++; $display("FAIL abort_txn: got %0d expected 1", txn_w); end
    for (int t = 2; t <= 16; t++) begin
      bw.req = 1'b1; bw.cmd = 1'b0; bw.addr = 32'h4;
      lat = 0;
      do begin
        tick();
        lat++;
      end while (!bw.ack && lat < 20);
      bw.req = 1'b0;
      if (t == 2) begin
        n_cmp++; if (bw.rdata !== 32'h5) begin n_err++; $display("FAIL abort_committed: got %h expected 5", bw.rdata); end
      end
      tick();
      if (t == 15) begin
        n_cmp++; if (txn_w !== 4'hF) begin n_err++; $display("FAIL wrap_max: got %0d expected 15", txn_w); end
      end
      if (t == 16) begin
        n_cmp++; if (txn_w !== 4'h0) begin n_err++; $display("FAIL wrap_zero: got %0d expected 0", txn_w); end
      end
    end
  endtask

  initial begin
    bm.req = 1'b0; bm.cmd = 1'b0; bm.addr = '0; bm.wdata = '0;
    bz.req = 1'b0; bz.cmd = 1'b0; bz.addr = '0; bz.wdata = '0;
    bw.req = 1'b0; bw.cmd = 1'b0; bw.addr = '0; bw.wdata = '0;
    test_reset();
    test_latency();
    test_back_to_back();
    test_capture();
    test_alias();
    test_abort_wrap();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
